// File: rtl/bus_fifo_burst_reader.sv
// Read-side controller for the wide bus FIFO: pops entries and streams them as BURST_LEN-beat bursts.
// Define BUS_FIFO_RD_TIMEOUT_EN to pad a stalled partial burst with a filler beat after TIMEOUT empty cycles.
module bus_fifo_burst_reader #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IN_DEPTH  = 6,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      enable,
  input  logic                      fifo_empty,
  input  logic [IN_DEPTH*WIDTH-1:0] fifo_rd_data,
  output logic                      fifo_rd_en,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [IN_DEPTH*WIDTH-1:0] m_data,
  output logic                      m_last,
  output logic                      m_pad,
  output logic                      busy,
  output logic [15:0]               burst_cnt
);
  localparam int unsigned DW  = IN_DEPTH * WIDTH;
  localparam int unsigned BIW = $clog2(BURST_LEN);

  if (BURST_LEN < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("bus_fifo_burst_reader: BURST_LEN must be >= 2 and TIMEOUT >= 1");
  end

`ifdef BUS_FIFO_RD_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, STREAM, PAD} state_t;
`else
  typedef enum logic [1:0] {IDLE, STREAM} state_t;
`endif

  state_t          state_q;
  logic [BIW-1:0]  beat_idx_q;
  logic            closing_q;
  logic            m_valid_q;
  logic [DW-1:0]   m_data_q;
  logic            m_last_q;
  logic [15:0]     burst_cnt_q;
  logic            closing_w;
  logic            last_beat;

  // Closing is decided at the burst boundary (beat_idx back at 0), so the
  // pop that would start a new burst is suppressed in the same cycle.
  assign closing_w  = closing_q ||
                      ((state_q == STREAM) && (beat_idx_q == '0) && (!enable || fifo_empty));
  assign last_beat  = (beat_idx_q == BIW'(BURST_LEN - 1));
  assign fifo_rd_en = (state_q == STREAM) && !fifo_empty && !closing_w && (!m_valid_q || m_ready);

`ifdef BUS_FIFO_RD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic          m_pad_q;
  logic          tmo_idle;
  logic          pad_start;

  assign tmo_idle  = (state_q == STREAM) && (beat_idx_q != '0) && fifo_empty && !m_valid_q;
  assign pad_start = tmo_idle && (tmo_q == TW'(TIMEOUT - 1));
  assign m_pad     = m_pad_q;
`else
  assign m_pad     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      beat_idx_q  <= '0;
      closing_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      burst_cnt_q <= '0;
`ifdef BUS_FIFO_RD_TIMEOUT_EN
      tmo_q       <= '0;
      m_pad_q     <= 1'b0;
`endif
    end else begin
      if (fifo_rd_en) begin
        m_data_q   <= fifo_rd_data;
        m_valid_q  <= 1'b1;
        m_last_q   <= last_beat;
        beat_idx_q <= last_beat ? '0 : beat_idx_q + 1'b1;
`ifdef BUS_FIFO_RD_TIMEOUT_EN
        m_pad_q    <= 1'b0;
      end else if (pad_start) begin
        m_data_q   <= '0;
        m_valid_q  <= 1'b1;
        m_last_q   <= 1'b1;
        m_pad_q    <= 1'b1;
`endif
      end else if (m_valid_q && m_ready) begin
        m_valid_q  <= 1'b0;
      end

      if (m_valid_q && m_ready && m_last_q) begin
        burst_cnt_q <= burst_cnt_q + 16'd1;
      end

`ifdef BUS_FIFO_RD_TIMEOUT_EN
      if (fifo_rd_en || state_q != STREAM) begin
        tmo_q <= '0;
      end else if (tmo_idle) begin
        tmo_q <= tmo_q + 1'b1;
      end
`endif

      unique case (state_q)
        IDLE: begin
          if (enable && !fifo_empty) state_q <= STREAM;
        end
        STREAM: begin
          if (closing_w && (!m_valid_q || m_ready)) begin
            state_q   <= IDLE;
            closing_q <= 1'b0;
          end else if (closing_w) begin
            closing_q <= 1'b1;
`ifdef BUS_FIFO_RD_TIMEOUT_EN
          end else if (pad_start) begin
            state_q   <= PAD;
`endif
          end
        end
`ifdef BUS_FIFO_RD_TIMEOUT_EN
        PAD: begin
          if (m_valid_q && m_ready) begin
            state_q    <= IDLE;
            beat_idx_q <= '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign busy      = (state_q != IDLE);
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_bus_fifo_burst_reader.sv
// Scoreboard bench for bus_fifo_burst_reader: a queue-backed FIFO model feeds the DUT and
// every accepted beat is compared against the expected entry order and burst framing.
module tb_bus_fifo_burst_reader;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned IN_DEPTH = 6;
  localparam int unsigned BL       = 4;
  localparam int unsigned TMO      = 16;
  localparam int unsigned DW       = WIDTH * IN_DEPTH;

  logic          clk = 1'b0;
  logic          rstn, enable, fifo_empty, fifo_rd_en;
  logic          m_valid, m_ready, m_last, m_pad, busy;
  logic [DW-1:0] fifo_rd_data, m_data;
  logic [15:0]   burst_cnt;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          pad;
  } beat_t;

  logic [DW-1:0] fifo_m[$];
  beat_t         exp_q[$];

  int unsigned   n_tests = 0, n_fail = 0;
  int unsigned   cyc = 0, beats = 0, model_idx = 0;
  int unsigned   last_data_cyc = 0, pad_cyc = 0, b0 = 0;
  logic [15:0]   model_bursts = '0;
  logic          s_valid, s_rden, s_busy, s_hs;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always #5 clk = ~clk;

  bus_fifo_burst_reader #(
    .WIDTH    (WIDTH),
    .IN_DEPTH (IN_DEPTH),
    .BURST_LEN(BL),
    .TIMEOUT  (TMO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_pad       (m_pad),
    .busy        (busy),
    .burst_cnt   (burst_cnt)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_entry();
    logic [DW-1:0] d;
    for (int unsigned i = 0; i < IN_DEPTH; i++) d[i*WIDTH +: WIDTH] = $urandom;
    return d;
  endfunction

  task automatic fifo_refresh();
    fifo_empty   = (fifo_m.size() == 0);
    fifo_rd_data = (fifo_m.size() == 0) ? '0 : fifo_m[0];
  endtask

  task automatic push(input int unsigned n);
    beat_t e;
    for (int unsigned i = 0; i < n; i++) begin
      e.data = mk_entry();
      e.pad  = 1'b0;
      fifo_m.push_back(e.data);
      exp_q.push_back(e);
    end
    fifo_refresh();
  endtask

  task automatic flush();
    fifo_m.delete();
    exp_q.delete();
    fifo_refresh();
  endtask

  // One clock: sample and score at the falling edge, apply the FIFO pop just after the rising edge.
  task automatic tick();
    beat_t e;
    logic  exp_last;
    @(negedge clk);
    s_valid = m_valid;
    s_rden  = fifo_rd_en;
    s_busy  = busy;
    s_hs    = m_valid && m_ready;
    if (rstn) begin
      if (stall_prev) begin
        check("hold_data", m_data, stall_data);
        check("hold_valid", DW'(m_valid), DW'(1));
      end
      if (m_valid && !m_ready) check("rd_in_stall", DW'(fifo_rd_en), DW'(0));
      if (fifo_rd_en) check("rd_nonempty", DW'(fifo_empty), DW'(0));
      if (m_valid && m_ready) begin
        beats++;
        check("beat_expected", DW'(exp_q.size() != 0), DW'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          exp_last = e.pad || (model_idx == BL - 1);
          check("data", m_data, e.data);
          check("pad", DW'(m_pad), DW'(e.pad));
          check("last", DW'(m_last), DW'(exp_last));
          if (e.pad) pad_cyc = cyc;
          else last_data_cyc = cyc;
          model_idx = exp_last ? 0 : model_idx + 1;
          if (exp_last) model_bursts = model_bursts + 16'd1;
        end
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (s_rden && fifo_m.size() != 0) void'(fifo_m.pop_front());
    fifo_refresh();
  endtask

  task automatic wait_beats(input string tag, input int unsigned target, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (beats >= target) break;
      tick();
    end
    check(tag, DW'(beats >= target), DW'(1));
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      tick();
      if (!s_busy) break;
    end
    check(tag, DW'(s_busy), DW'(0));
  endtask

  initial begin
    rstn    = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b0;
    fifo_refresh();
    repeat (3) tick();
    check("rst_valid", DW'(m_valid), DW'(0));
    check("rst_last", DW'(m_last), DW'(0));
    check("rst_pad", DW'(m_pad), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_rden", DW'(fifo_rd_en), DW'(0));
    check("rst_bcnt", DW'(burst_cnt), DW'(0));
    rstn = 1'b1;
    tick();

    // 1: preloaded 8 entries, full throughput
    push(8);
    m_ready = 1'b1;
    enable  = 1'b1;
    tick();
    check("t1_lat0", DW'(s_valid), DW'(0));
    tick();
    check("t1_lat1", DW'(s_valid), DW'(0));
    check("t1_first_pop", DW'(s_rden), DW'(1));
    for (int unsigned i = 0; i < 8; i++) begin
      tick();
      check("t1_b2b", DW'(s_hs), DW'(1));
    end
    wait_idle("t1_idle", 10);
    check("t1_bcnt", DW'(burst_cnt), DW'(model_bursts));
    check("t1_bcnt2", DW'(burst_cnt), DW'(2));
    check("t1_fifo_left", DW'(fifo_m.size()), DW'(0));
    enable = 1'b0;

    // 2: alternating ready, stall stability checked in tick
    push(8);
    b0     = beats;
    enable = 1'b1;
    for (int unsigned i = 0; i < 80; i++) begin
      if (beats >= b0 + 8) break;
      m_ready = cyc[0];
      tick();
    end
    check("t2_beats", DW'(beats - b0), DW'(8));
    m_ready = 1'b1;
    wait_idle("t2_idle", 10);
    check("t2_bcnt", DW'(burst_cnt), DW'(model_bursts));
    enable = 1'b0;

    // 3: partial burst, FIFO gap, then completion
    push(2);
    b0     = beats;
    enable = 1'b1;
    wait_beats("t3_first2", b0 + 2, 20);
    repeat (10) tick();
    check("t3_gap_valid", DW'(s_valid), DW'(0));
    check("t3_gap_busy", DW'(s_busy), DW'(1));
    push(2);
    wait_beats("t3_rest", b0 + 4, 20);
    wait_idle("t3_idle", 10);
    check("t3_bcnt", DW'(burst_cnt), DW'(model_bursts));
    check("t3_idx", DW'(model_idx), DW'(0));
    enable = 1'b0;

    // 4: enable drops after the first beat; burst completes, 2 entries stay queued
    push(6);
    b0     = beats;
    enable = 1'b1;
    wait_beats("t4_beat1", b0 + 1, 20);
    enable = 1'b0;
    wait_idle("t4_idle", 20);
    check("t4_beats", DW'(beats - b0), DW'(4));
    check("t4_fifo_left", DW'(fifo_m.size()), DW'(2));
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("t4_no_pop", DW'(s_rden), DW'(0));
    end
    check("t4_bcnt", DW'(burst_cnt), DW'(model_bursts));
    flush();

`ifdef BUS_FIFO_RD_TIMEOUT_EN
    // 5: three entries then empty; a filler beat closes the burst
    begin
      beat_t e;
      push(3);
      e.data = '0;
      e.pad  = 1'b1;
      exp_q.push_back(e);
    end
    b0     = beats;
    enable = 1'b1;
    wait_beats("t5_beats", b0 + 4, 80);
    check("t5_gap", DW'(pad_cyc - last_data_cyc), DW'(TMO + 1));
    wait_idle("t5_idle", 10);
    check("t5_bcnt", DW'(burst_cnt), DW'(model_bursts));
    enable = 1'b0;
`endif

    // 6: reset in the middle of a burst
    push(4);
    b0     = beats;
    enable = 1'b1;
    wait_beats("t6_beat2", b0 + 2, 20);
    rstn = 1'b0;
    #1;
    check("t6_rst_valid", DW'(m_valid), DW'(0));
    check("t6_rst_bcnt", DW'(burst_cnt), DW'(0));
    check("t6_rst_busy", DW'(busy), DW'(0));
    model_idx    = 0;
    model_bursts = '0;
    stall_prev   = 1'b0;
    flush();
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    push(4);
    b0 = beats;
    wait_beats("t6_refill", b0 + 4, 20);
    wait_idle("t6_idle", 10);
    check("t6_bcnt", DW'(burst_cnt), DW'(model_bursts));
    check("t6_bcnt1", DW'(burst_cnt), DW'(1));
    check("t6_sb_empty", DW'(exp_q.size()), DW'(0));
    enable = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
